// File: rtl/ins_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// LOADER_CHECKSUM_EN adds the trailing checksum state.
package ins_loader_pkg;

    localparam int WORD_BYTES = 4;
    localparam int BYTE_W     = 8;
    localparam int WORD_W     = WORD_BYTES * BYTE_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RECV,
        ST_WRITE,
        ST_FIN,
        ST_LOADED
`ifdef LOADER_CHECKSUM_EN
        , ST_CHK
`endif
    } state_t;

endpackage

// File: rtl/ins_word_packer.sv
// Collects stream bytes into one big-endian word; the first byte lands in the MSB.
// word_valid flags the cycle whose accepted byte completes the word.
module ins_word_packer
    import ins_loader_pkg::*;
(
    input  logic              clk,
    input  logic              RST,
    input  logic              clear,
    input  logic              byte_en,
    input  logic [BYTE_W-1:0] byte_data,
    output logic [WORD_W-1:0] word,
    output logic              word_valid
);

    localparam int CNT_W = $clog2(WORD_BYTES);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (RST) begin
            cnt  <= '0;
            word <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (byte_en) begin
            cnt  <= cnt + 1'b1;
            // Shifting left means the earliest byte ends up in the top lane.
            word <= {word[WORD_W-BYTE_W-1:0], byte_data};
        end
    end

    assign word_valid = byte_en && (cnt == CNT_W'(WORD_BYTES - 1));

endmodule

// File: rtl/ins_loader.sv
// Instruction-memory loader: packs a byte stream into words, writes them from address 0
// and holds the CPU in reset until the load completes. LOADER_CHECKSUM_EN adds chk_err.
//
// state     | meaning
// ST_IDLE   | no image loaded, CPU held in reset
// ST_RECV   | accepting bytes of the current word
// ST_WRITE  | one-cycle instruction-memory write
// ST_CHK    | (checksum build) accepting the XOR checksum byte
// ST_FIN    | done pulse, CPU released next cycle
// ST_LOADED | image loaded, CPU running
module ins_loader
    import ins_loader_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              start,
    input  logic [ADDR_W:0]   load_len,
    input  logic              byte_valid,
    input  logic [BYTE_W-1:0] byte_data,
    output logic              byte_ready,
    output logic              InsWrEN,
    output logic [ADDR_W-1:0] InsWrAddr,
    output logic [WORD_W-1:0] InsDataIn,
    output logic              cpu_nRST,
    output logic              busy,
    output logic              done
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic              chk_err
`endif
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
`ifdef LOADER_CHECKSUM_EN
    localparam state_t ST_AFTER_PAYLOAD = ST_CHK;
`else
    localparam state_t ST_AFTER_PAYLOAD = ST_FIN;
`endif

    state_t            state, state_nxt;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   len_clamped;
    logic [ADDR_W-1:0] idx_q;
    logic [ADDR_W-1:0] addr_hold;
    logic [WORD_W-1:0] data_hold;
    logic [WORD_W-1:0] word;
    logic              word_valid;
    logic              start_ok;
    logic              byte_en;
    logic              last_word;
    logic              chk_fail;

    assign len_clamped = (load_len > DEPTH_L) ? DEPTH_L : load_len;
    assign start_ok    = start && ((state == ST_IDLE) || (state == ST_LOADED));
    assign byte_en     = byte_valid && (state == ST_RECV);
    assign last_word   = ({1'b0, idx_q} == (len_q - 1'b1));

    assign InsWrEN   = (state == ST_WRITE);
    assign cpu_nRST  = (state == ST_LOADED);
    // Write port shows the live word only during WRITE and holds the last write otherwise.
    assign InsWrAddr = InsWrEN ? idx_q : addr_hold;
    assign InsDataIn = InsWrEN ? word  : data_hold;

`ifdef LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0] csum;

    assign byte_ready = (state == ST_RECV) || (state == ST_CHK);
    assign busy       = (state == ST_RECV) || (state == ST_WRITE) || (state == ST_CHK);
    assign chk_fail   = (state == ST_CHK) && byte_valid && (byte_data != csum);

    always_ff @(posedge clk) begin
        if (RST) begin
            csum    <= '0;
            chk_err <= 1'b0;
        end else if (start_ok) begin
            csum    <= '0;
            chk_err <= 1'b0;
        end else begin
            if (byte_en)  csum    <= csum ^ byte_data;
            if (chk_fail) chk_err <= 1'b1;
        end
    end
`else
    assign byte_ready = (state == ST_RECV);
    assign busy       = (state == ST_RECV) || (state == ST_WRITE);
    assign chk_fail   = 1'b0;
`endif

    assign done = (state == ST_FIN) || chk_fail;

    ins_word_packer u_packer (
        .clk        (clk),
        .RST        (RST),
        .clear      (start_ok || (state == ST_WRITE)),
        .byte_en    (byte_en),
        .byte_data  (byte_data),
        .word       (word),
        .word_valid (word_valid)
    );

    always_ff @(posedge clk) begin
        if (RST) begin
            state     <= ST_IDLE;
            len_q     <= '0;
            idx_q     <= '0;
            addr_hold <= '0;
            data_hold <= '0;
        end else begin
            state <= state_nxt;
            if (start_ok) begin
                len_q <= len_clamped;
                idx_q <= '0;
            end
            if (state == ST_WRITE) begin
                addr_hold <= idx_q;
                data_hold <= word;
                if (!last_word) idx_q <= idx_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_LOADED: begin
                if (start) state_nxt = (len_clamped == '0) ? ST_AFTER_PAYLOAD : ST_RECV;
            end
            ST_RECV:  if (word_valid) state_nxt = ST_WRITE;
            ST_WRITE: state_nxt = last_word ? ST_AFTER_PAYLOAD : ST_RECV;
`ifdef LOADER_CHECKSUM_EN
            ST_CHK:   if (byte_valid) state_nxt = chk_fail ? ST_IDLE : ST_FIN;
`endif
            ST_FIN:   state_nxt = ST_LOADED;
            default:  state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ins_loader.sv
// Randomized scoreboard bench for ins_loader: expected writes are queued from a
// word-level model and a negedge monitor checks every InsWrEN cycle against them.
module tb_ins_loader;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        RST = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  load_len = '0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = '0;
    logic        byte_ready;
    logic        InsWrEN;
    logic [4:0]  InsWrAddr;
    logic [31:0] InsDataIn;
    logic        cpu_nRST;
    logic        busy;
    logic        done;
`ifdef LOADER_CHECKSUM_EN
    logic        chk_err;
`endif

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    int exp_dones = 0;
    wr_t sb[$];

    ins_loader #(.ADDR_W(5), .DEPTH(32)) dut (
        .clk        (clk),
        .RST        (RST),
        .start      (start),
        .load_len   (load_len),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .InsWrEN    (InsWrEN),
        .InsWrAddr  (InsWrAddr),
        .InsDataIn  (InsDataIn),
        .cpu_nRST   (cpu_nRST),
        .busy       (busy),
        .done       (done)
`ifdef LOADER_CHECKSUM_EN
        ,
        .chk_err    (chk_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: every write must match the head of the scoreboard.
    always @(negedge clk) begin
        wr_t e;
        if (!RST) begin
            if (done) done_cnt++;
            if (InsWrEN) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write addr=%0d data=%h required=no_write", InsWrAddr, InsDataIn);
                end else begin
                    e = sb.pop_front();
                    chk("wr_addr", 64'(InsWrAddr), 64'(e.addr));
                    chk("wr_data", 64'(InsDataIn), 64'(e.data));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_start(input int len);
        start    = 1'b1;
        load_len = 6'(len);
        tick();
        start    = 1'b0;
    endtask

    // Presents each byte until the DUT takes it; optional idle gaps and ignored start pulses.
    task automatic stream(input logic [7:0] bytes[$], input bit gaps, input bit poke);
        int i = 0;
        int guard = 0;
        while (i < bytes.size() && guard < 4000) begin
            if (gaps && $urandom_range(0, 1) == 1) begin
                byte_valid = 1'b0;
                byte_data  = 8'($urandom);
            end else begin
                byte_valid = 1'b1;
                byte_data  = bytes[i];
            end
            start    = poke && ($urandom_range(0, 7) == 0);
            load_len = 6'($urandom);
            @(negedge clk);
            if (byte_valid && byte_ready) i++;
            tick();
            start = 1'b0;
            guard++;
        end
        byte_valid = 1'b0;
        chk("stream_timeout", 64'(guard >= 4000), 64'(0));
    endtask

    task automatic wait_done(output int waited);
        waited = 0;
        while (!done && waited < 20) begin
            tick();
            waited++;
        end
        chk("done_seen", 64'(done), 64'(1));
        chk("fin_busy", 64'(busy), 64'(0));
        chk("fin_cpu_held", 64'(cpu_nRST), 64'(0));
        tick();
        chk("done_one_cycle", 64'(done), 64'(0));
        chk("cpu_released", 64'(cpu_nRST), 64'(1));
    endtask

    // Reference: first min(len,32) words go to addresses 0.., each sent MSB byte first.
    task automatic run_load(input int len, input logic [31:0] words[$], input bit gaps, input bit poke,
                            output int waited);
        int eff;
        logic [7:0] bytes[$];
        logic [7:0] x;
        logic [31:0] w;
        eff = (len > 32) ? 32 : len;
        x = 8'h00;
        for (int k = 0; k < eff; k++) begin
            w = words[k];
            sb.push_back('{addr: 5'(k), data: w});
            for (int b = 3; b >= 0; b--) begin
                bytes.push_back(w[b*8 +: 8]);
                x = x ^ w[b*8 +: 8];
            end
        end
`ifdef LOADER_CHECKSUM_EN
        bytes.push_back(x);
`endif
        issue_start(len);
        if (eff > 0) begin
            chk("load_busy", 64'(busy), 64'(1));
            chk("load_cpu_held", 64'(cpu_nRST), 64'(0));
        end
        stream(bytes, gaps, poke);
        wait_done(waited);
        exp_dones++;
        chk("sb_drained", 64'(sb.size()), 64'(0));
    endtask

    initial begin
        logic [31:0] words[$];
        logic [7:0] part[$];
        int waited;
        int len;

        repeat (3) tick();
        chk("rst_wren", 64'(InsWrEN), 64'(0));
        chk("rst_addr", 64'(InsWrAddr), 64'(0));
        chk("rst_data", 64'(InsDataIn), 64'(0));
        chk("rst_busy_done", 64'({busy, done}), 64'(0));
        RST = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("idle_outputs", 64'({cpu_nRST, byte_ready, busy}), 64'(0));
        end

        words = '{32'h8C010004, 32'h20020005};
        run_load(2, words, 1'b0, 1'b0, waited);
        run_load(2, words, 1'b1, 1'b1, waited);

        words.delete();
        for (int k = 0; k < 40; k++) words.push_back($urandom);
        run_load(40, words, 1'b0, 1'b1, waited);

        // Reset after six bytes of a three-word load: only word 0 lands.
        words.delete();
        for (int k = 0; k < 3; k++) words.push_back($urandom);
        sb.push_back('{addr: 5'd0, data: words[0]});
        for (int k = 0; k < 6; k++) part.push_back(words[k/4][(3 - k%4)*8 +: 8]);
        issue_start(3);
        stream(part, 1'b1, 1'b0);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("rst_mid_state", 64'({cpu_nRST, byte_ready, busy, InsWrEN}), 64'(0));
        chk("rst_mid_writes", 64'(sb.size()), 64'(0));
        tick();
        chk("rst_mid_idle", 64'({cpu_nRST, byte_ready}), 64'(0));
        run_load(3, words, 1'b1, 1'b0, waited);

        words.delete();
        run_load(0, words, 1'b0, 1'b0, waited);
`ifndef LOADER_CHECKSUM_EN
        chk("len0_done_latency", 64'(waited), 64'(0));
`endif

`ifdef LOADER_CHECKSUM_EN
        words = '{32'h12345678};
        run_load(1, words, 1'b0, 1'b0, waited);
        chk("chk_ok_err", 64'(chk_err), 64'(0));
        sb.push_back('{addr: 5'd0, data: 32'h12345678});
        part = '{8'h12, 8'h34, 8'h56, 8'h78};
        issue_start(1);
        stream(part, 1'b0, 1'b0);
        waited = 0;
        while (!byte_ready && waited < 10) begin
            tick();
            waited++;
        end
        byte_valid = 1'b1;
        byte_data  = 8'h09;
        @(negedge clk);
        chk("chk_bad_done", 64'(done), 64'(1));
        exp_dones++;
        tick();
        byte_valid = 1'b0;
        chk("chk_bad_err", 64'(chk_err), 64'(1));
        chk("chk_bad_cpu", 64'({cpu_nRST, busy}), 64'(0));
`endif

        for (int r = 0; r < 6; r++) begin
            len = $urandom_range(0, 40);
            words.delete();
            for (int k = 0; k < len; k++) words.push_back($urandom);
            run_load(len, words, 1'($urandom_range(0, 1)), 1'b1, waited);
        end

        repeat (3) tick();
        chk("done_count", 64'(done_cnt), 64'(exp_dones));
        chk("final_sb_empty", 64'(sb.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
